// File: rtl/exe_mem_reg_if.sv
// EXE/MEM boundary bundle: stall/flush controls, execute-stage
// results going in, and registered memory-stage values coming out.
interface exe_mem_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4
);
    logic              freeze;
    logic              flush;
    logic              valid_in;
    logic              s_in;
    logic [3:0]        status_in;
    logic [DATA_W-1:0] alu_res_in;
    logic [DATA_W-1:0] val_rm_in;
    logic [REG_W-1:0]  dest_in;
    logic              wb_en_in;
    logic              mem_r_en_in;
    logic              mem_w_en_in;

    logic [3:0]        status_out;
    logic [DATA_W-1:0] alu_res_out;
    logic [DATA_W-1:0] val_rm_out;
    logic [REG_W-1:0]  dest_out;
    logic              wb_en_out;
    logic              mem_r_en_out;
    logic              mem_w_en_out;
    logic              valid_out;
    logic [15:0]       upd_cnt;

    modport master (
        output freeze, flush, valid_in, s_in, status_in,
        output alu_res_in, val_rm_in, dest_in,
        output wb_en_in, mem_r_en_in, mem_w_en_in,
        input  status_out, alu_res_out, val_rm_out, dest_out,
        input  wb_en_out, mem_r_en_out, mem_w_en_out,
        input  valid_out, upd_cnt
    );

    modport slave (
        input  freeze, flush, valid_in, s_in, status_in,
        input  alu_res_in, val_rm_in, dest_in,
        input  wb_en_in, mem_r_en_in, mem_w_en_in,
        output status_out, alu_res_out, val_rm_out, dest_out,
        output wb_en_out, mem_r_en_out, mem_w_en_out,
        output valid_out, upd_cnt
    );
endinterface

// File: rtl/exe_mem_reg.sv
// EXE/MEM pipeline register; also holds the architectural NZCV
// flags that feed back to the ALU carry input.
module exe_mem_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4
) (
    input logic          clk,
    input logic          rst,
    exe_mem_reg_if.slave bus
);
    logic [3:0]        status_q;
    logic [DATA_W-1:0] alu_res_q;
    logic [DATA_W-1:0] val_rm_q;
    logic [REG_W-1:0]  dest_q;
    logic              wb_en_q;
    logic              mem_r_en_q;
    logic              mem_w_en_q;
    logic              valid_q;
    logic [15:0]       cnt_q;
    logic              upd;

    assign upd = bus.valid_in & bus.s_in;

    always_ff @(posedge clk) begin
        if (!rst) begin
            status_q   <= '0;
            alu_res_q  <= '0;
            val_rm_q   <= '0;
            dest_q     <= '0;
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            mem_w_en_q <= 1'b0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
        end else if (bus.freeze) begin
            // stall: hold everything, flush is re-issued later
        end else if (bus.flush) begin
            alu_res_q  <= '0;
            val_rm_q   <= '0;
            dest_q     <= '0;
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            mem_w_en_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            alu_res_q  <= bus.alu_res_in;
            val_rm_q   <= bus.val_rm_in;
            dest_q     <= bus.dest_in;
            wb_en_q    <= bus.wb_en_in & bus.valid_in;
            mem_r_en_q <= bus.mem_r_en_in & bus.valid_in;
            mem_w_en_q <= bus.mem_w_en_in & bus.valid_in;
            valid_q    <= bus.valid_in;
            if (upd) begin
                status_q <= bus.status_in;
                if (cnt_q != 16'hFFFF)
                    cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign bus.status_out   = status_q;
    assign bus.alu_res_out  = alu_res_q;
    assign bus.val_rm_out   = val_rm_q;
    assign bus.dest_out     = dest_q;
    assign bus.wb_en_out    = wb_en_q;
    assign bus.mem_r_en_out = mem_r_en_q;
    assign bus.mem_w_en_out = mem_w_en_q;
    assign bus.valid_out    = valid_q;
    assign bus.upd_cnt      = cnt_q;
endmodule

// File: tb/tb_exe_mem_reg.sv
// Randomized bench for exe_mem_reg against a cycle-level
// behavioural model of the stage register and flag file.
module tb_exe_mem_reg;
    localparam int DW = 32;
    localparam int RW = 4;
    localparam int OW = 4 + DW + DW + RW + 4 + 16;

    logic clk;
    logic rst;
    int   nvec;
    int   nbad;

    exe_mem_reg_if #(.DATA_W(DW), .REG_W(RW)) bus ();

    exe_mem_reg #(.DATA_W(DW), .REG_W(RW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expected architectural state
    logic [3:0]    m_st;
    logic [DW-1:0] m_alu;
    logic [DW-1:0] m_rm;
    logic [RW-1:0] m_dest;
    logic          m_wb, m_mr, m_mw, m_v;
    int            m_cnt;

    function automatic logic [OW-1:0] obs();
        return {bus.status_out, bus.alu_res_out, bus.val_rm_out,
                bus.dest_out, bus.wb_en_out, bus.mem_r_en_out,
                bus.mem_w_en_out, bus.valid_out, bus.upd_cnt};
    endfunction

    function automatic logic [OW-1:0] mdl();
        logic [15:0] c;
        c = 16'(m_cnt);
        return {m_st, m_alu, m_rm, m_dest, m_wb, m_mr, m_mw, m_v, c};
    endfunction

    task automatic model_edge();
        if (!rst) begin
            m_st = 0; m_alu = 0; m_rm = 0; m_dest = 0;
            m_wb = 0; m_mr = 0; m_mw = 0; m_v = 0; m_cnt = 0;
        end else if (bus.freeze) begin
        end else if (bus.flush) begin
            m_alu = 0; m_rm = 0; m_dest = 0;
            m_wb = 0; m_mr = 0; m_mw = 0; m_v = 0;
        end else begin
            m_alu  = bus.alu_res_in;
            m_rm   = bus.val_rm_in;
            m_dest = bus.dest_in;
            m_v    = bus.valid_in;
            m_wb   = bus.valid_in ? bus.wb_en_in : 1'b0;
            m_mr   = bus.valid_in ? bus.mem_r_en_in : 1'b0;
            m_mw   = bus.valid_in ? bus.mem_w_en_in : 1'b0;
            if (bus.valid_in && bus.s_in) begin
                m_st  = bus.status_in;
                m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic fz, input logic fl,
                         input logic v, input logic s,
                         input logic [3:0] st,
                         input logic [DW-1:0] alu,
                         input logic [RW-1:0] d,
                         input logic wb, input logic mr,
                         input logic mw);
        bus.freeze      = fz;
        bus.flush       = fl;
        bus.valid_in    = v;
        bus.s_in        = s;
        bus.status_in   = st;
        bus.alu_res_in  = alu;
        bus.val_rm_in   = $urandom;
        bus.dest_in     = d;
        bus.wb_en_in    = wb;
        bus.mem_r_en_in = mr;
        bus.mem_w_en_in = mw;
    endtask

    task automatic drive_rand();
        logic rd;
        rd = 1'($urandom);
        drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 3) != 0), 1'($urandom),
              4'($urandom), $urandom, RW'($urandom), 1'($urandom),
              rd & 1'($urandom), ~rd & 1'($urandom));
    endtask

    always @(negedge clk) begin
        if (bus.mem_r_en_out && bus.mem_w_en_out) begin
            nbad++;
            $display("FAIL rw_excl: got r=1 w=1 need not both");
        end
    end

    task automatic test_reset();
        rst = 1'b0;
        drive(1, 1, 1, 1, 4'hF, '1, '1, 1, 1, 1);
        bus.val_rm_in = '1;
        for (int i = 0; i < 2; i++) begin
            step();
            nvec++;
            if (obs() !== '0) begin
                nbad++;
                $display("FAIL reset: got %h need 0", obs());
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_load();
        drive(0, 0, 1, 1, 4'b0010, 32'h10, 4'd3, 1, 0, 0);
        step();
        nvec++;
        if ({bus.alu_res_out, bus.dest_out, bus.wb_en_out,
             bus.status_out, bus.upd_cnt}
            !== {32'h10, 4'd3, 1'b1, 4'b0010, 16'd1}) begin
            nbad++;
            $display("FAIL load: got alu=%h d=%0d wb=%b st=%b c=%0d",
                     bus.alu_res_out, bus.dest_out, bus.wb_en_out,
                     bus.status_out, bus.upd_cnt);
        end
        nvec++;
        if (obs() !== mdl()) begin
            nbad++;
            $display("FAIL load_all: got %h need %h", obs(), mdl());
        end
    endtask

    task automatic test_no_s();
        drive(0, 0, 1, 0, 4'b1000, 32'h20, 4'd4, 1, 1, 0);
        step();
        nvec++;
        if (bus.status_out !== 4'b0010 || obs() !== mdl()) begin
            nbad++;
            $display("FAIL no_s: got %h need %h", obs(), mdl());
        end
        drive(0, 0, 0, 1, 4'b1000, 32'h30, 4'd5, 1, 0, 1);
        step();
        nvec++;
        if ({bus.wb_en_out, bus.valid_out, bus.mem_w_en_out,
             bus.status_out} !== {3'b000, 4'b0010}) begin
            nbad++;
            $display("FAIL bubble: got wb=%b v=%b mw=%b st=%b need 0 0 0 0010",
                     bus.wb_en_out, bus.valid_out, bus.mem_w_en_out,
                     bus.status_out);
        end
    endtask

    task automatic test_freeze();
        logic [OW-1:0] held;
        drive(0, 0, 1, 1, 4'b0010, 32'h10, 4'd3, 1, 0, 0);
        step();
        held = mdl();
        for (int i = 0; i < 4; i++) begin
            drive(1, (i == 3), 1, 1, 4'b0101, 32'hDEAD, 4'd9, 1, 1, 0);
            step();
            nvec++;
            if (obs() !== held || bus.alu_res_out !== 32'h10 ||
                bus.status_out !== 4'b0010) begin
                nbad++;
                $display("FAIL freeze%0d: got %h need %h", i, obs(), held);
            end
        end
    endtask

    task automatic test_flush();
        logic [3:0]  st0;
        logic [15:0] c0;
        st0 = bus.status_out;
        c0  = bus.upd_cnt;
        drive(0, 1, 1, 1, 4'b1111, 32'h55, 4'd7, 1, 0, 1);
        step();
        nvec++;
        if ({bus.valid_out, bus.mem_w_en_out, bus.alu_res_out,
             bus.status_out, bus.upd_cnt}
            !== {1'b0, 1'b0, 32'h0, st0, c0}) begin
            nbad++;
            $display("FAIL flush: got v=%b mw=%b alu=%h st=%b c=%0d",
                     bus.valid_out, bus.mem_w_en_out, bus.alu_res_out,
                     bus.status_out, bus.upd_cnt);
        end
    endtask

    task automatic test_back_to_back();
        drive(0, 0, 1, 1, 4'b0010, 32'h1, 4'd1, 1, 0, 0);
        step();
        nvec++;
        if (bus.status_out[1] !== 1'b1) begin
            nbad++;
            $display("FAIL b2b_carry: got C=%b need 1", bus.status_out[1]);
        end
        drive(0, 0, 1, 1, 4'b0000, 32'h2, 4'd2, 1, 0, 0);
        step();
        nvec++;
        if (bus.status_out !== 4'b0000 || obs() !== mdl()) begin
            nbad++;
            $display("FAIL b2b_second: got %h need %h", obs(), mdl());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive_rand();
            step();
            nvec++;
            if (obs() !== mdl()) begin
                nbad++;
                $display("FAIL rand%0d: got %h need %h", i, obs(), mdl());
            end
        end
    endtask

    task automatic test_counter();
        rst = 1'b0;
        step();
        rst = 1'b1;
        drive(0, 0, 1, 1, 4'($urandom), $urandom, 4'd1, 1, 0, 0);
        while (m_cnt < 65534) begin
            bus.status_in = 4'($urandom);
            step();
            if ((m_cnt % 8192) == 0) begin
                nvec++;
                if (obs() !== mdl()) begin
                    nbad++;
                    $display("FAIL cnt_ramp: got %h need %h", obs(), mdl());
                end
            end
        end
        nvec++;
        if (bus.upd_cnt !== 16'hFFFE) begin
            nbad++;
            $display("FAIL cnt_pre: got %h need fffe", bus.upd_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            bus.status_in = 4'($urandom);
            step();
            nvec++;
            if (bus.upd_cnt !== 16'hFFFF || obs() !== mdl()) begin
                nbad++;
                $display("FAIL cnt_sat%0d: got %h need ffff", i, bus.upd_cnt);
            end
        end
        drive(1, 1, 1, 1, 4'hF, '1, '1, 1, 0, 1);
        rst = 1'b0;
        step();
        nvec++;
        if (obs() !== '0) begin
            nbad++;
            $display("FAIL rst_mid: got %h need 0", obs());
        end
        rst = 1'b1;
    endtask

    initial begin
        nvec = 0;
        nbad = 0;
        rst  = 1'b0;
        drive(0, 0, 0, 0, 4'h0, '0, '0, 0, 0, 0);
        #2;
        test_reset();
        test_load();
        test_no_s();
        test_freeze();
        test_flush();
        test_back_to_back();
        test_random();
        test_counter();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule

// File: doc/exe_mem_reg.md
Name: exe_mem_reg

Overview:
- Pipeline register between the execute-stage ALU and the memory stage.
- Captures the ALU result, store data, destination and control bits each cycle.
- Owns the architectural NZCV status register. Its output feeds back into the ALU Status input, so the carry for ADC/SBC comes from here.
- Supports freeze (memory stall hold), flush (bubble insertion) and conditional status update (S bit).

Parameters:
- DATA_W, 32, width of ALU result and store data.
- REG_W, 4, width of register-file address (destination).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset: sampled on rising clk, asserted when 0.
- freeze  in  1  hold all state (memory stall).
- flush  in  1  insert bubble; discard the current EXE instruction.
- valid_in  in  1  EXE slot holds a real instruction.
- s_in  in  1  instruction requests status update.
- status_in  in  4  {N,Z,C,V} from ALU Status_Out: bit3 N, bit2 Z, bit1 C, bit0 V.
- alu_res_in  in  DATA_W  ALU result.
- val_rm_in  in  DATA_W  store data.
- dest_in  in  REG_W  writeback register.
- wb_en_in, mem_r_en_in, mem_w_en_in  in  1 each  control bits.
- status_out  out  4  architectural NZCV, to ALU Status input.
- alu_res_out  out  DATA_W  registered result.
- val_rm_out  out  DATA_W  registered store data.
- dest_out  out  REG_W  registered destination.
- wb_en_out, mem_r_en_out, mem_w_en_out, valid_out  out  1 each  registered controls.
- upd_cnt  out  16  count of status updates; saturates.

Behaviour:
- Reset (rst==0 at posedge): every output and internal register = 0, including status_out = 4'b0000 and upd_cnt = 0.
- Priority at each posedge: reset > freeze > flush > normal load.
- freeze==1:
  - All registers, status and counter hold.
  - flush is ignored that cycle; the hazard unit re-asserts flush after the stall.
- flush==1 (freeze==0):
  - valid_out, wb_en_out, mem_r_en_out and mem_w_en_out load 0.
  - Data fields and dest load 0.
  - Status and counter hold.
- Normal load (freeze==0, flush==0):
  - All *_out load their *_in values. Latency is exactly 1 cycle.
  - Control outputs are gated by valid_in: when valid_in==0, wb_en/mem_r_en/mem_w_en_out load 0.
- Status update condition: valid_in & s_in & ~freeze & ~flush.
  - When true, status_out <= status_in at the same posedge as the data load.
  - Otherwise status holds.
  - Consequence: the next ALU op sees the new carry one cycle after the setting instruction. Back-to-back ADS then ADC therefore reads the updated C.
  - Under a stalled freeze the held instruction never double-updates flags.
- upd_cnt:
  - Increments by 1 on each status update.
  - Saturates at 16'hFFFF with no wrap.
  - Holds under freeze/flush.
- Mid-operation reset: reset takes effect at the next posedge regardless of freeze/flush. There is no partial update; status is cleared together with the data.
- No combinational path from any input to any output: all outputs are registered.
- mem_r_en_out and mem_w_en_out are never both 1 out of the block when the inputs are legal. The block does not check this; the bench asserts it.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with all inputs at max value -> every output 0, status_out=0000, upd_cnt=0.
2. Normal load: valid_in=1, alu_res_in=32'h0000_0010, dest_in=4'd3, wb_en_in=1, s_in=1, status_in=4'b0010 -> next cycle alu_res_out=0x10, dest_out=3, wb_en_out=1, status_out=0010, upd_cnt=1.
3. No-S and bubble:
   - s_in=0, status_in=4'b1000 -> status_out stays 0010.
   - valid_in=0, wb_en_in=1 -> wb_en_out=0, valid_out=0.
4. Freeze: with stage loaded as in scenario 2, assert freeze=1 for 3 cycles with s_in=1, status_in=4'b0101, alu_res_in=0xDEAD -> outputs and status_out unchanged (0x10, 0010), upd_cnt unchanged. Also drive flush=1 during freeze -> still no change.
5. Flush: flush=1, valid_in=1, s_in=1, status_in=4'b1111, mem_w_en_in=1 -> next cycle valid_out=0, mem_w_en_out=0, alu_res_out=0, status_out unchanged.
6. Counter and reset mid-op:
   - Preload upd_cnt to 16'hFFFE, then 3 consecutive S updates -> upd_cnt=FFFF and stays.
   - Then rst=0 while freeze=1 -> all outputs 0 next cycle.
